rrb_param: RTL
==============

Name: rrb_param

Overview:
- Parametrised round-robin arbiter, successor to the fixed 4-requester RR arbiter.
- Grants one of N requesters and holds the grant across a multi-cycle transaction until the winner signals done, drops its request, or exceeds a hold limit.
- Sits in front of a shared resource (bus port, memory channel).
- Outputs a registered one-hot grant, an encoded index, and a timeout pulse.

Parameters:
- N, 4, number of requesters; legal range 1..32.
- MAX_HOLD, 16, maximum cycles a grant may be held; 0 = unlimited.
- GAP, 1, 1 = one idle cycle after each release before the next grant; 0 = back-to-back grants.
- IDX_W, max(1,$clog2(N)), width of the encoded grant index (derived; do not override).

Ports:
- clk_i  in  1  clock; all state on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  N  request per requester; level-sensitive.
- done_i  in  1  granted requester's transaction complete; sampled only while grant_valid_o=1.
- grant_o  out  N  registered one-hot grant; all-zero when idle.
- grant_valid_o  out  1  high when grant_o is non-zero.
- grant_idx_o  out  IDX_W  binary index of the current or last winner.
- timeout_o  out  1  one-cycle pulse on forced release at MAX_HOLD.

Behaviour:
- Reset (async assert, sync deassert by upstream):
  - grant_o=0, grant_valid_o=0, grant_idx_o=0, timeout_o=0.
  - Hold counter=0, state=IDLE.
  - Priority pointer=N-1, so requester 0 has highest priority first.
- Arbitration (combinational pick): search starts at pointer+1 and wraps modulo N; the first set req_i bit wins.
- State IDLE:
  - If any req_i is set at edge t, the pick is registered: grant_o one-hot and grant_valid_o=1 from cycle t+1.
  - On the same edge: pointer <- winner, grant_idx_o <- winner, hold counter <- 1; go to GRANT.
  - Latency is 1 cycle from request to grant.
- State GRANT: release conditions, evaluated each cycle:
  - (a) done_i=1.
  - (b) req_i[winner]=0.
  - (c) MAX_HOLD!=0 and hold counter==MAX_HOLD.
- On release with GAP=1: next cycle grant_o=0 and grant_valid_o=0; state goes to IDLE.
- On release with GAP=0: arbitration runs in the release cycle using the updated rotation, and the next grant is registered on the same edge.
  - The released winner is lowest priority and re-wins only if it is the sole requester.
  - If no request is present, go to IDLE.
- No release: hold the grant and increment the counter, saturating at MAX_HOLD.
- timeout_o pulses 1 cycle (registered, coincident with grant removal) only when release is caused solely by (c).
  - If done_i or a request drop occurs in the same cycle, there is no timeout pulse.
- grant_idx_o retains the last winner while idle.
- Grant changes only on clock edges. Never more than one grant bit is set.
- Async reset mid-GRANT clears the grant immediately, with no timeout pulse.
- N=1: the pointer is constant and the requester is re-granted per the GAP rule.
- Hold counter width is $clog2(MAX_HOLD+1), minimum 1.
- done_i while IDLE is ignored.

Decomposition:
- Package rrb_pkg:
  - state enum {IDLE, GRANT}.
  - Function for one-hot to index.
  - Localparam helpers for IDX_W and counter width.
- Sub-module rrb_pick (combinational):
  - Inputs req, pointer. Outputs one-hot pick and any.
  - Implemented as a double-width masked priority search.
- rrb_param owns the FSM, pointer, hold counter and output registers.

Test Plan:
1. Fairness: N=4, GAP=1, all req_i=4'b1111 held, done_i pulsed each grant -> grants 0,1,2,3,0 in order, each followed by one idle cycle.
2. Back-to-back: GAP=0, req_i=4'b0101, done_i after 2 grant cycles each -> grant_o alternates 0001/0100 with no zero cycle; grant_idx_o 0,2,0,2.
3. Timeout: MAX_HOLD=3, req_i[1] held, done_i=0 -> grant_o=0010 for exactly 3 cycles, then timeout_o=1 for one cycle and grant_o=0.
4. Simultaneous: done_i=1 in the cycle the hold counter reaches MAX_HOLD -> grant released, timeout_o stays 0.
5. Request drop: req_i[2] deasserted mid-grant -> grant_o cleared next cycle; pointer=2, so a subsequent req_i=4'b0101 grants index 0.
6. Reset mid-operation: rst_ni low while grant_o=1000 -> outputs zero asynchronously; after release, req_i=4'b1111 grants index 0 first.

Source files
------------

// File: rtl/rrb_pkg.sv
// rrb_pkg: shared types and sizing helpers for the parametrised round-robin arbiter
package rrb_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int MAX_N     = 32;
    localparam int IDX_MAX_W = 5;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int m);
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

    function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [IDX_MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++)
            if (oh[i]) idx = idx | IDX_MAX_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rrb_pick.sv
// rrb_pick: rotating priority pick, first set request after the pointer wins
module rrb_pick
    import rrb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic             any
);

    logic [2*N-1:0] masked;

    // lower copy is cleared up to the pointer so the search starts at ptr+1 and wraps into the upper copy
    always_comb begin
        masked = {req, req};
        for (int i = 0; i < N; i++)
            if (i <= int'(ptr)) masked[i] = 1'b0;
        pick = '0;
        for (int i = 2*N-1; i >= 0; i--)
            if (masked[i]) begin
                pick = '0;
                pick[i % N] = 1'b1;
            end
    end

    assign any = |req;

endmodule

// File: rtl/rrb_param.sv
// rrb_param: round-robin arbiter holding each grant until done, request drop or hold limit
module rrb_param
    import rrb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int GAP      = 1,
    parameter int IDX_W    = idx_width(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    input  logic             done_i,
    output logic [N-1:0]     grant_o,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             timeout_o
);

    localparam int CW = cnt_width(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CW-1:0]    cnt;
    logic [N-1:0]     pick;
    logic             any;
    logic [MAX_N-1:0] pick_ext;
    logic [IDX_W-1:0] pick_idx;
    logic             rel_done;
    logic             rel_drop;
    logic             rel_hold;
    logic             rel;
    logic             take;

    rrb_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req  (req_i),
        .ptr  (ptr),
        .pick (pick),
        .any  (any)
    );

    // encode the pick and decide whether the current grant ends and whether a new one starts
    always_comb begin
        pick_ext = '0;
        pick_ext[N-1:0] = pick;
        pick_idx = IDX_W'(onehot_to_idx(pick_ext));
        rel_done = done_i;
        rel_drop = !req_i[grant_idx_o];
        rel_hold = (MAX_HOLD != 0) && (cnt == HOLD_MAX);
        rel = (state == GRANT) && (rel_done || rel_drop || rel_hold);
        take = any && ((state == IDLE) || (rel && GAP == 0));
    end

    // arbiter FSM with pointer, hold counter and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            ptr           <= IDX_W'(N - 1);
            cnt           <= '0;
            grant_o       <= '0;
            grant_valid_o <= 1'b0;
            grant_idx_o   <= '0;
            timeout_o     <= 1'b0;
        end else begin
            timeout_o <= rel && rel_hold && !rel_done && !rel_drop;
            if (take) begin
                state         <= GRANT;
                grant_o       <= pick;
                grant_valid_o <= 1'b1;
                grant_idx_o   <= pick_idx;
                ptr           <= pick_idx;
                cnt           <= CW'(1);
            end else if (rel) begin
                state         <= IDLE;
                grant_o       <= '0;
                grant_valid_o <= 1'b0;
            end else if (state == GRANT && MAX_HOLD != 0) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
